bsort_host_adapter: RTL
=======================

BSORT_HOST_ADAPTER -- requirements
Module: bsort_host_adapter

Interface
REQ-001 SHALL have parameter N_WORDS, default 8, number of 32-bit words loaded into and read back from accelerator memory (1..31).
REQ-002 SHALL have parameter BASE_ADDR, default 32, byte address of word 0 in the accelerator slave memory space.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 200000000, maximum run cycles before abort.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset as the codebase does.
REQ-005 clock  input  1  single rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 go  input  1  one-cycle pulse that starts a load/run/readback sequence, sampled only in IDLE.
REQ-008 in_data / in_valid / in_ready  input / input / output  32 / 1 / 1  host word stream into accelerator memory.
REQ-009 out_data / out_valid / out_ready  output / output / input  32 / 1 / 1  result word stream to host.
REQ-010 start_port  output  1  start pulse to accelerator.
REQ-011 done_port  input  1  accelerator completion.
REQ-012 S_oe_ram, S_we_ram  output  2 each  per-channel read and write enables, with channel 0 in bit 0.
REQ-013 S_addr_ram  output  14  per-channel 7-bit address, with channel 0 in [6:0].
REQ-014 S_Wdata_ram  output  128  per-channel 64-bit write data, with channel 0 in [63:0].
REQ-015 S_data_ram_size  output  14  per-channel 7-bit access size in bits, with channel 0 in [6:0].
REQ-016 Sout_Rdata_ram / Sout_DataRdy  input / input  128 / 2  per-channel read data and read-valid.
REQ-017 cycles / busy / finished / timeout  output  32 / 1 / 1 / 1  run length, active flag, sequence-complete flag, abort flag.

Function
REQ-018 SHALL tie channel 1 of every slave output to zero at all times.
REQ-019 SHALL drive channel 0 with access size 32, address BASE_ADDR+4*i (7-bit, wraps modulo 128), and write data {32'd0, word}.
REQ-020 SHALL implement states IDLE, LOAD, START, RUN, READ_REQ, READ_WAIT, DRAIN, and DONE.
REQ-021 IDLE: go=1 -> LOAD, which clears the word index i, cycles, finished and timeout; busy=1 in every state except IDLE and DONE.
REQ-022 LOAD: in_ready=1; each in_valid&in_ready cycle -> S_we_ram[0]=1 for exactly that cycle with word i, then i increments; after word N_WORDS-1 -> START.
REQ-023 START: start_port=1 for exactly one cycle -> RUN; cycles counts every START and RUN cycle, so the START cycle counts as 1.
REQ-024 RUN: done_port=1 sampled -> READ_REQ with i=0, and the sampling cycle is counted.
REQ-025 RUN: if cycles reaches TIMEOUT_CYCLES before done_port -> DONE with timeout=1 and no readback.
REQ-026 READ_REQ: S_oe_ram[0]=1 for one cycle at word i -> READ_WAIT.
REQ-027 READ_WAIT: hold until Sout_DataRdy[0]=1, then capture Sout_Rdata_ram[31:0] -> DRAIN; no read timeout.
REQ-028 DRAIN: out_valid=1 and out_data held stable until out_ready=1; on the handshake, i increments, then -> READ_REQ, or -> DONE after word N_WORDS-1.
REQ-029 DONE: finished=1 and cycles held until the next go -> LOAD; go outside IDLE/DONE SHALL be ignored.
REQ-030 Only one of S_we_ram[0] and S_oe_ram[0] SHALL be high in any cycle.
REQ-031 cycles SHALL saturate at 32'hFFFF_FFFF.

Reset
REQ-032 Reset SHALL force IDLE, with every output, i and cycles at 0, including mid-sequence (start_port and slave enables drop immediately).
REQ-033 After reset deassertion, the first go SHALL be accepted on the first rising edge.

Verification
REQ-034 N_WORDS=4, stream 4,3,2,1 back-to-back -> four single-cycle writes at addresses 32, 36, 40, 44; then one start_port pulse.
REQ-035 done_port high 10 cycles after the start_port cycle -> cycles=11; readback of 4 words, each DataRdy 2 cycles after oe -> out stream in address order; then finished=1.
REQ-036 in_valid gaps and out_ready held low for 5 cycles -> no lost or duplicated word, and out_data stable while stalled.
REQ-037 TIMEOUT_CYCLES=20, done_port never asserted -> timeout=1, cycles=20, no S_oe_ram pulse, finished=1.
REQ-038 reset asserted during READ_WAIT -> all outputs 0 asynchronously, then a fresh go completes a full sequence normally.
REQ-039 go pulsed during RUN -> ignored, with cycles unaffected.

Source files
------------

// File: rtl/bsort_host_adapter.sv
// Host-side adapter for a bubble-sort accelerator: streams words into slave
// memory, starts the core, times the run, and streams the results back out.
module bsort_host_adapter #(
    parameter int N_WORDS        = 8,
    parameter int BASE_ADDR      = 32,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         go,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         start_port,
    input  logic         done_port,
    output logic [1:0]   S_oe_ram,
    output logic [1:0]   S_we_ram,
    output logic [13:0]  S_addr_ram,
    output logic [127:0] S_Wdata_ram,
    output logic [13:0]  S_data_ram_size,
    input  logic [127:0] Sout_Rdata_ram,
    input  logic [1:0]   Sout_DataRdy,
    output logic [31:0]  cycles,
    output logic         busy,
    output logic         finished,
    output logic         timeout
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_READ_REQ  = 3'd4;
    localparam logic [2:0] S_READ_WAIT = 3'd5;
    localparam logic [2:0] S_DRAIN     = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam logic [4:0]  LAST_IDX = 5'(N_WORDS - 1);
    localparam logic [31:0] TMO_LIM  = 32'(TIMEOUT_CYCLES);

    logic [2:0]  state_q, state_d;
    logic [4:0]  i_q, i_d;
    logic [31:0] cycles_q, cycles_d;
    logic        finished_q, finished_d;
    logic        timeout_q, timeout_d;
    logic [31:0] out_data_q, out_data_d;
    logic [31:0] cycles_inc_s;
    logic [6:0]  addr_s;
    logic        we0_s, oe0_s;
    logic        unused_bits_s;

    // Upper channel-0 read data and channel-1 ready are not consumed.
    assign unused_bits_s = ^{Sout_Rdata_ram[127:32], Sout_DataRdy[1]};

    assign cycles_inc_s = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
    assign addr_s       = 7'(BASE_ADDR) + {i_q, 2'b00};

    // Next-state and datapath update for the load/run/readback sequence.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        cycles_d   = cycles_q;
        finished_d = finished_q;
        timeout_d  = timeout_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d    = S_LOAD;
                    i_d        = 5'd0;
                    cycles_d   = 32'd0;
                    finished_d = 1'b0;
                    timeout_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (in_valid && (i_q == LAST_IDX)) begin
                    state_d = S_START;
                    i_d     = 5'd0;
                end else if (in_valid) begin
                    i_d = i_q + 5'd1;
                end else begin
                    i_d = i_q;
                end
            end
            S_START: begin
                cycles_d = cycles_inc_s;
                state_d  = S_RUN;
            end
            S_RUN: begin
                cycles_d = cycles_inc_s;
                // Completion wins over a timeout landing on the same cycle.
                if (done_port) begin
                    state_d = S_READ_REQ;
                    i_d     = 5'd0;
                end else if (cycles_inc_s >= TMO_LIM) begin
                    state_d    = S_DONE;
                    timeout_d  = 1'b1;
                    finished_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_READ_REQ: state_d = S_READ_WAIT;
            S_READ_WAIT: begin
                if (Sout_DataRdy[0]) begin
                    out_data_d = Sout_Rdata_ram[31:0];
                    state_d    = S_DRAIN;
                end else begin
                    state_d = S_READ_WAIT;
                end
            end
            S_DRAIN: begin
                if (out_ready && (i_q == LAST_IDX)) begin
                    state_d    = S_DONE;
                    finished_d = 1'b1;
                end else if (out_ready) begin
                    i_d     = i_q + 5'd1;
                    state_d = S_READ_REQ;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            i_q        <= 5'd0;
            cycles_q   <= 32'd0;
            finished_q <= 1'b0;
            timeout_q  <= 1'b0;
            out_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            cycles_q   <= cycles_d;
            finished_q <= finished_d;
            timeout_q  <= timeout_d;
            out_data_q <= out_data_d;
        end
    end

    // Enables decode from the state register so a reset drops them at once.
    assign we0_s = (state_q == S_LOAD) && in_valid;
    assign oe0_s = (state_q == S_READ_REQ);

    assign in_ready        = (state_q == S_LOAD);
    assign out_valid       = (state_q == S_DRAIN);
    assign out_data        = out_data_q;
    assign start_port      = (state_q == S_START);
    assign S_we_ram        = {1'b0, we0_s};
    assign S_oe_ram        = {1'b0, oe0_s};
    assign S_addr_ram      = {7'd0, (we0_s || oe0_s) ? addr_s : 7'd0};
    assign S_data_ram_size = {7'd0, (we0_s || oe0_s) ? 7'd32 : 7'd0};
    assign S_Wdata_ram     = {64'd0, 32'd0, we0_s ? in_data : 32'd0};
    assign cycles          = cycles_q;
    assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign finished        = finished_q;
    assign timeout         = timeout_q;

endmodule
